// File: rtl/sram_mem_ctrl.sv
// rtl/sram_mem_ctrl.sv - SLC-3 MAR/MDR to asynchronous SRAM access sequencer
module sram_mem_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req_Valid,
    output logic              Req_Ready,
    input  logic              Req_Write,
    input  logic [ADDR_W-1:0] Req_Addr,
    input  logic [15:0]       Req_Wdata,
    output logic              Rsp_Valid,
    output logic [15:0]       Rsp_Data,
    output logic              Busy,
    output logic [19:0]       SRAM_ADDR,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N,
    output logic [15:0]       SRAM_DQ_Out,
    output logic              SRAM_DQ_OE,
    input  logic [15:0]       SRAM_DQ_In
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        WR_SETUP = 3'd2,
        WR_PULSE = 3'd3,
        WR_HOLD  = 3'd4
    } state_t;

    // Strobe-low time is WAIT_CYCLES; the counter runs WAIT_CYCLES-1 down to 0.
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [15:0]       rsp_data_q, rsp_data_d;

    // State and datapath registers; reset releases the bus immediately.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            wdata_q     <= 16'h0000;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 16'h0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Next-state, wait counter, request capture and completion pulse.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (Req_Valid) begin
                    addr_d  = Req_Addr;
                    wdata_d = Req_Wdata;
                    cnt_d   = CNT_LOAD;
                    state_d = Req_Write ? WR_SETUP : RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_data_d  = SRAM_DQ_In;
                    rsp_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            WR_SETUP: state_d = WR_PULSE;
            WR_PULSE: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                else               state_d = WR_HOLD;
            end
            WR_HOLD: begin
                rsp_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore decode of the SRAM strobes and pad enable from the registered state.
    always_comb begin
        SRAM_CE_N  = 1'b1;
        SRAM_OE_N  = 1'b1;
        SRAM_WE_N  = 1'b1;
        SRAM_UB_N  = 1'b1;
        SRAM_LB_N  = 1'b1;
        SRAM_DQ_OE = 1'b0;
        case (state_q)
            RD_WAIT: begin
                SRAM_CE_N = 1'b0;
                SRAM_OE_N = 1'b0;
                SRAM_UB_N = 1'b0;
                SRAM_LB_N = 1'b0;
            end
            WR_SETUP, WR_HOLD: begin
                SRAM_CE_N  = 1'b0;
                SRAM_UB_N  = 1'b0;
                SRAM_LB_N  = 1'b0;
                SRAM_DQ_OE = 1'b1;
            end
            WR_PULSE: begin
                SRAM_CE_N  = 1'b0;
                SRAM_WE_N  = 1'b0;
                SRAM_UB_N  = 1'b0;
                SRAM_LB_N  = 1'b0;
                SRAM_DQ_OE = 1'b1;
            end
            default: ;
        endcase
    end

    assign Req_Ready   = (state_q == IDLE);
    assign Busy        = (state_q != IDLE);
    assign Rsp_Valid   = rsp_valid_q;
    assign Rsp_Data    = rsp_data_q;
    assign SRAM_ADDR   = {{(20-ADDR_W){1'b0}}, addr_q};
    assign SRAM_DQ_Out = wdata_q;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// tb/tb_sram_mem_ctrl.sv - directed-vector bench for sram_mem_ctrl
module tb_sram_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          n_vec = 0;
    int          n_err = 0;

    // WAIT_CYCLES = 2 instance
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [15:0] req_addr = 16'h0, req_wdata = 16'h0;
    logic        req_ready, rsp_valid, busy;
    logic [15:0] rsp_data, dq_out, dq_in;
    logic [19:0] sram_addr;
    logic        ce_n, oe_n, we_n, ub_n, lb_n, dq_oe;
    logic [5:0]  strb;

    // WAIT_CYCLES = 1 instance
    logic        req_valid1 = 1'b0;
    logic [15:0] req_addr1 = 16'h0;
    logic        req_ready1, rsp_valid1, busy1;
    logic [15:0] rsp_data1, dq_out1, dq_in1;
    logic [19:0] sram_addr1;
    logic        ce_n1, oe_n1, we_n1, ub_n1, lb_n1, dq_oe1;
    logic [5:0]  strb1;

    logic [15:0] mem [0:65535];

    localparam logic [5:0] S_IDLE = 6'b111110;
    localparam logic [5:0] S_RD   = 6'b001000;
    localparam logic [5:0] S_WSH  = 6'b011001;
    localparam logic [5:0] S_WP   = 6'b010001;

    always #5 clk = ~clk;

    sram_mem_ctrl #(.WAIT_CYCLES(2), .ADDR_W(16)) dut (
        .Clk(clk), .Reset(rst), .Req_Valid(req_valid), .Req_Ready(req_ready),
        .Req_Write(req_write), .Req_Addr(req_addr), .Req_Wdata(req_wdata),
        .Rsp_Valid(rsp_valid), .Rsp_Data(rsp_data), .Busy(busy), .SRAM_ADDR(sram_addr),
        .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n), .SRAM_UB_N(ub_n),
        .SRAM_LB_N(lb_n), .SRAM_DQ_Out(dq_out), .SRAM_DQ_OE(dq_oe), .SRAM_DQ_In(dq_in)
    );

    sram_mem_ctrl #(.WAIT_CYCLES(1), .ADDR_W(16)) dut1 (
        .Clk(clk), .Reset(rst), .Req_Valid(req_valid1), .Req_Ready(req_ready1),
        .Req_Write(1'b0), .Req_Addr(req_addr1), .Req_Wdata(16'h0000),
        .Rsp_Valid(rsp_valid1), .Rsp_Data(rsp_data1), .Busy(busy1), .SRAM_ADDR(sram_addr1),
        .SRAM_CE_N(ce_n1), .SRAM_OE_N(oe_n1), .SRAM_WE_N(we_n1), .SRAM_UB_N(ub_n1),
        .SRAM_LB_N(lb_n1), .SRAM_DQ_Out(dq_out1), .SRAM_DQ_OE(dq_oe1), .SRAM_DQ_In(dq_in1)
    );

    assign strb  = {ce_n, oe_n, we_n, ub_n, lb_n, dq_oe};
    assign strb1 = {ce_n1, oe_n1, we_n1, ub_n1, lb_n1, dq_oe1};

    // Asynchronous SRAM model: reads while CE/OE low, writes while CE/WE low.
    assign dq_in  = (!ce_n && !oe_n) ? mem[sram_addr[15:0]] : 16'h0000;
    assign dq_in1 = (!ce_n1 && !oe_n1) ? mem[sram_addr1[15:0]] : 16'h0000;
    always @(posedge clk) begin
        if (!ce_n && !we_n && dq_oe) mem[sram_addr[15:0]] = dq_out;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h3000] = 16'hBEEF;
        mem[16'hFFFF] = 16'h5A5A;

        // Reset state
        cyc();
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_strb", 32'(strb), 32'(S_IDLE));
        check("rst_rspv", 32'(rsp_valid), 32'd0);
        check("rst_rspd", 32'(rsp_data), 32'h0000);
        rst = 1'b0;
        cyc();

        // Read 0x3000, two wait cycles
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h3000;
        cyc();
        req_valid = 1'b0;
        check("rd_strb1", 32'(strb), 32'(S_RD));
        check("rd_addr", 32'(sram_addr), 32'h03000);
        check("rd_busy", 32'(busy), 32'd1);
        check("rd_ready", 32'(req_ready), 32'd0);
        check("rd_rspv1", 32'(rsp_valid), 32'd0);
        cyc();
        check("rd_strb2", 32'(strb), 32'(S_RD));
        check("rd_rspv2", 32'(rsp_valid), 32'd0);
        cyc();
        check("rd_strb3", 32'(strb), 32'(S_IDLE));
        check("rd_rspv", 32'(rsp_valid), 32'd1);
        check("rd_data", 32'(rsp_data), 32'hBEEF);
        cyc();
        check("rd_rspv_off", 32'(rsp_valid), 32'd0);

        // Write 0x1234 to 0x00FF
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h00FF; req_wdata = 16'h1234;
        cyc();
        req_valid = 1'b0;
        check("wr_setup", 32'(strb), 32'(S_WSH));
        check("wr_addr", 32'(sram_addr), 32'h000FF);
        check("wr_dq", 32'(dq_out), 32'h1234);
        cyc();
        check("wr_pulse1", 32'(strb), 32'(S_WP));
        cyc();
        check("wr_pulse2", 32'(strb), 32'(S_WP));
        check("wr_rspv_p", 32'(rsp_valid), 32'd0);
        cyc();
        check("wr_hold", 32'(strb), 32'(S_WSH));
        check("wr_dq_hold", 32'(dq_out), 32'h1234);
        cyc();
        check("wr_idle", 32'(strb), 32'(S_IDLE));
        check("wr_rspv", 32'(rsp_valid), 32'd1);
        check("wr_rspd", 32'(rsp_data), 32'hBEEF);
        check("wr_mem", 32'(mem[16'h00FF]), 32'h1234);
        cyc();

        // Write 0x0010 then read it back, presented in the ack cycle
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0010; req_wdata = 16'h1234;
        cyc();
        req_valid = 1'b0;
        cyc(); cyc(); cyc(); cyc();
        check("b2b_ack", 32'(rsp_valid), 32'd1);
        check("b2b_turn", 32'(strb), 32'(S_IDLE));
        check("b2b_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0010;
        cyc();
        req_valid = 1'b0;
        check("b2b_acc", 32'(strb), 32'(S_RD));
        cyc(); cyc();
        check("b2b_rspv", 32'(rsp_valid), 32'd1);
        check("b2b_data", 32'(rsp_data), 32'h1234);
        cyc();

        // Address changes mid-read are ignored; second request waits
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h3000;
        cyc();
        req_addr = 16'hAAAA;
        check("mid_addr1", 32'(sram_addr), 32'h03000);
        cyc();
        check("mid_addr2", 32'(sram_addr), 32'h03000);
        check("mid_busy", 32'(busy), 32'd1);
        cyc();
        check("mid_rspv", 32'(rsp_valid), 32'd1);
        check("mid_data", 32'(rsp_data), 32'hBEEF);
        cyc();
        req_valid = 1'b0;
        check("mid_acc2", 32'(sram_addr), 32'h0AAAA);
        check("mid_busy2", 32'(busy), 32'd1);
        cyc(); cyc();
        check("mid_rspv2", 32'(rsp_valid), 32'd1);
        cyc();

        // Reset in the second write-pulse cycle
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0020; req_wdata = 16'h5555;
        cyc();
        req_valid = 1'b0;
        cyc(); cyc();
        check("rmid_pulse2", 32'(strb), 32'(S_WP));
        rst = 1'b1;
        #1;
        check("rmid_strb", 32'(strb), 32'(S_IDLE));
        check("rmid_busy", 32'(busy), 32'd0);
        check("rmid_rspd", 32'(rsp_data), 32'h0000);
        cyc();
        rst = 1'b0;
        check("rmid_rspv0", 32'(rsp_valid), 32'd0);
        cyc();
        check("rmid_rspv1", 32'(rsp_valid), 32'd0);
        check("rmid_idle", 32'(strb), 32'(S_IDLE));

        // WAIT_CYCLES = 1, read 0xFFFF
        req_valid1 = 1'b1; req_addr1 = 16'hFFFF;
        cyc();
        req_valid1 = 1'b0;
        check("w1_strb", 32'(strb1), 32'(S_RD));
        check("w1_addr", 32'(sram_addr1), 32'h0FFFF);
        check("w1_rspv0", 32'(rsp_valid1), 32'd0);
        cyc();
        check("w1_rspv", 32'(rsp_valid1), 32'd1);
        check("w1_data", 32'(rsp_data1), 32'h5A5A);
        check("w1_idle", 32'(strb1), 32'(S_IDLE));
        cyc();
        check("w1_rspv_off", 32'(rsp_valid1), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
